// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler in front of UART_tx.
// Sends each granted 16-bit word as two bytes via trmt/tx_data.
module uart_tx_sched #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        grant0,
  output logic        grant1,
  output logic        done0,
  output logic        done1,
  output logic        busy,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND1 = 3'd1,
    WAIT1 = 3'd2,
    SEND2 = 3'd3,
    WAIT2 = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_owner;
  logic [15:0] r_buf;
  logic        r_grant0;
  logic        r_grant1;
  logic        r_done0;
  logic        r_done1;
  logic        r_busy;
  logic        r_trmt;
  logic [7:0]  r_tx_data;

  logic        w_any;
  logic        w_sel;
  logic [15:0] w_word;
  logic [7:0]  w_first;
  logic [7:0]  w_second;

  // On a tie, the requester not served last wins.
  assign w_any    = req0 | req1;
  assign w_sel    = (req0 & req1) ? ~r_last : req1;
  assign w_word   = w_sel ? data1 : data0;
  assign w_first  = MSB_FIRST ? w_word[15:8] : w_word[7:0];
  assign w_second = MSB_FIRST ? r_buf[7:0] : r_buf[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_buf     <= 16'h0000;
      r_grant0  <= 1'b0;
      r_grant1  <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_busy    <= 1'b0;
      r_trmt    <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_trmt   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_buf     <= w_word;
            r_owner   <= w_sel;
            r_last    <= w_sel;
            r_grant0  <= ~w_sel;
            r_grant1  <= w_sel;
            r_trmt    <= 1'b1;
            r_tx_data <= w_first;
            r_busy    <= 1'b1;
            r_state   <= SEND1;
          end
        end
        SEND1: r_state <= WAIT1;
        WAIT1: begin
          if (tx_done) begin
            r_trmt    <= 1'b1;
            r_tx_data <= w_second;
            r_state   <= SEND2;
          end
        end
        SEND2: r_state <= WAIT2;
        WAIT2: begin
          if (tx_done) begin
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign grant0  = r_grant0;
  assign grant1  = r_grant1;
  assign done0   = r_done0;
  assign done1   = r_done1;
  assign busy    = r_busy;
  assign trmt    = r_trmt;
  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: MSB-first and LSB-first instances share
// stimulus; the bench plays the UART_tx tx_done handshake.
module tb_uart_tx_sched;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] data0, data1;
  logic        tx_done;

  logic       m_g0, m_g1, m_d0, m_d1, m_busy, m_trmt;
  logic [7:0] m_txd;
  logic       l_g0, l_g1, l_d0, l_d1, l_busy, l_trmt;
  logic [7:0] l_txd;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last;

  uart_tx_sched #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .grant0(m_g0), .grant1(m_g1), .done0(m_d0), .done1(m_d1),
    .busy(m_busy), .trmt(m_trmt), .tx_data(m_txd), .tx_done(tx_done)
  );

  uart_tx_sched #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .grant0(l_g0), .grant1(l_g1), .done0(l_d0), .done1(l_d1),
    .busy(l_busy), .trmt(l_trmt), .tx_data(l_txd), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          r0;
    bit          r1;
    logic [15:0] d0;
    logic [15:0] d1;
    int          own;
    logic [15:0] word;
    bit          chg;
    logic [15:0] nd;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // order: grant0 grant1 done0 done1 busy trmt
  task automatic expect_out(input string nm, input bit g0, input bit g1,
                            input bit d0, input bit d1, input bit b,
                            input bit t);
    chk({nm, "/msb"}, {10'b0, m_g0, m_g1, m_d0, m_d1, m_busy, m_trmt},
        {10'b0, g0, g1, d0, d1, b, t});
    chk({nm, "/lsb"}, {10'b0, l_g0, l_g1, l_d0, l_d1, l_busy, l_trmt},
        {10'b0, g0, g1, d0, d1, b, t});
  endtask

  task automatic expect_byte(input string nm, input logic [7:0] hb,
                             input logic [7:0] lb);
    chk({nm, "/msb"}, {8'h0, m_txd}, {8'h0, hb});
    chk({nm, "/lsb"}, {8'h0, l_txd}, {8'h0, lb});
  endtask

  // Called #1 after an edge where the DUT is idle and requests are set.
  task automatic run_packet(input int own, input logic [15:0] w,
                            input int gap1, input int gap2,
                            input bit chg, input logic [15:0] nd);
    @(posedge clk); #1;
    expect_out("grant", own == 0, own == 1, 0, 0, 1, 1);
    expect_byte("byte1", w[15:8], w[7:0]);
    if (own == 0) req0 = 1'b0; else req1 = 1'b0;
    if (chg) begin
      if (own == 0) data0 = nd; else data1 = nd;
    end
    @(posedge clk); #1;
    tx_done = 1'b0;
    expect_out("send1", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < gap1; i++) begin
      @(posedge clk); #1;
      expect_out("wait1", 0, 0, 0, 0, 1, 0);
      expect_byte("hold1", w[15:8], w[7:0]);
    end
    tx_done = 1'b1;
    @(posedge clk); #1;
    expect_out("trmt2", 0, 0, 0, 0, 1, 1);
    expect_byte("byte2", w[7:0], w[15:8]);
    @(posedge clk); #1;
    tx_done = 1'b0;
    expect_out("send2", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < gap2; i++) begin
      @(posedge clk); #1;
      expect_out("wait2", 0, 0, 0, 0, 1, 0);
      expect_byte("hold2", w[7:0], w[15:8]);
    end
    tx_done = 1'b1;
    @(posedge clk); #1;
    expect_out("done", 0, 0, own == 0, own == 1, 0, 0);
  endtask

  initial begin
    int          own;
    bit          r0, r1;
    logic [15:0] w;

    tbl[0] = '{1'b1, 1'b0, 16'hA55A, 16'h0000, 0, 16'hA55A, 1'b0, 16'h0};
    tbl[1] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1, 16'h2222, 1'b0, 16'h0};
    tbl[2] = '{1'b1, 1'b1, 16'h3333, 16'h4444, 0, 16'h3333, 1'b0, 16'h0};
    tbl[3] = '{1'b1, 1'b1, 16'h5566, 16'h7788, 1, 16'h7788, 1'b0, 16'h0};
    tbl[4] = '{1'b0, 1'b1, 16'h0000, 16'h9ABC, 1, 16'h9ABC, 1'b0, 16'h0};
    tbl[5] = '{1'b1, 1'b1, 16'h00FF, 16'hDEAD, 0, 16'h00FF, 1'b1, 16'hFFFF};
    tbl[6] = '{1'b0, 1'b1, 16'h0000, 16'hC3D2, 1, 16'hC3D2, 1'b0, 16'h0};

    rst_n = 1'b0; tx_done = 1'b1;
    req0 = 1'b0; req1 = 1'b0; data0 = 16'h0; data1 = 16'h0;
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    expect_byte("reset_txd", 8'h00, 8'h00);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_out("idle", 0, 0, 0, 0, 0, 0);

    // Tie right after reset: requester 0 first, then 1.
    req0 = 1'b1; req1 = 1'b1; data0 = 16'h1234; data1 = 16'hBEEF;
    run_packet(0, 16'h1234, 2, 3, 1'b0, 16'h0);
    run_packet(1, 16'hBEEF, 1, 2, 1'b0, 16'h0);

    foreach (tbl[k]) begin
      req0 = tbl[k].r0; req1 = tbl[k].r1;
      data0 = tbl[k].d0; data1 = tbl[k].d1;
      run_packet(tbl[k].own, tbl[k].word, 2, 2, tbl[k].chg, tbl[k].nd);
    end

    // Random traffic against a transaction-level arbitration model.
    m_last = 1;
    for (int p = 0; p < 30; p++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) begin
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
          @(posedge clk); #1;
          expect_out("noreq", 0, 0, 0, 0, 0, 0);
        end
        if ($urandom_range(0, 1) == 1) r0 = 1'b1; else r1 = 1'b1;
      end
      req0 = r0; req1 = r1;
      data0 = 16'($urandom); data1 = 16'($urandom);
      if (r0 && r1) own = 1 - m_last;
      else own = r1 ? 1 : 0;
      m_last = own;
      w = (own == 1) ? data1 : data0;
      run_packet(own, w, $urandom_range(1, 6), $urandom_range(1, 6),
                 1'($urandom_range(0, 1)), 16'($urandom));
    end

    // Reset while waiting for the second byte.
    req0 = 1'b1; req1 = 1'b0; data0 = 16'h5AA5;
    @(posedge clk); #1;
    expect_out("rst_grant", 1, 0, 0, 0, 1, 1);
    req0 = 1'b0;
    @(posedge clk); #1; tx_done = 1'b0;
    @(posedge clk); #1; tx_done = 1'b1;
    @(posedge clk); #1;
    expect_out("rst_trmt2", 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1; tx_done = 1'b0;
    @(posedge clk); #1;
    #3 rst_n = 1'b0; tx_done = 1'b1;
    #1;
    expect_out("midrst", 0, 0, 0, 0, 0, 0);
    expect_byte("midrst_txd", 8'h00, 8'h00);
    @(posedge clk); #1;
    expect_out("rst_hold", 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_out("post_rst", 0, 0, 0, 0, 0, 0);
    req1 = 1'b1; data1 = 16'h6789;
    run_packet(1, 16'h6789, 2, 2, 1'b0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
